// File: rtl/meta_burst_reader.sv
// ---------------------------------------------------------------------------
// meta_burst_reader
//
// Per-PE read sequencer placed directly in front of the PE's constant/meta
// ROM (bufferM). A burst command (start address, length-1) is turned into a
// run of sequential ROM addresses. The ROM's one-cycle registered read is
// absorbed by an in-flight stage, and the returned words are queued in a
// small response FIFO that drives a valid/ready stream. Reads are only issued
// while FIFO space is guaranteed (credit = free entries not yet claimed by an
// in-flight read), so downstream backpressure can never drop a word.
//
// Ports
//   clk        in   clock
//   reset      in   asynchronous, active-high reset
//   cmd_valid  in   burst command valid
//   cmd_ready  out  high in IDLE; command taken on cmd_valid && cmd_ready
//   cmd_addr   in   [addrLen]  first word address
//   cmd_len    in   [lenLen]   burst length minus one (0 = one word)
//   rom_addr   out  [addrLen]  ROM read address (current address register)
//   rom_data   in   [dataLen]  ROM read data, valid one edge after rom_addr
//   rsp_valid  out  response FIFO non-empty
//   rsp_ready  in   downstream accepts the head word
//   rsp_data   out  [dataLen]  head word (zero while the FIFO is empty)
//   rsp_last   out  head word is the final word of its burst
//   busy       out  burst active, read in flight, or FIFO non-empty
// ---------------------------------------------------------------------------
module meta_burst_reader #(
    parameter int addrLen    = 10,
    parameter int dataLen    = 32,
    parameter int lenLen     = 8,
    parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [addrLen-1:0] cmd_addr,
    input  logic [lenLen-1:0]  cmd_len,
    output logic [addrLen-1:0] rom_addr,
    input  logic [dataLen-1:0] rom_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [dataLen-1:0] rsp_data,
    output logic               rsp_last,
    output logic               busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_BURST = 1'b1;

    // Sequencer state
    logic [0:0]         r_state;
    logic [addrLen-1:0] r_cur_addr;
    logic [lenLen-1:0]  r_remaining;

    // In-flight read (ROM latency stage)
    logic               r_vld_p1;
    logic               r_last_p1;

    // Response FIFO; each entry is {last, data}
    logic [dataLen:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wptr;
    logic [PTR_W-1:0]   r_rptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_credit_ok;
    logic               w_issue;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [dataLen:0]   w_head;

    // Occupied entries plus the one read that may still be in flight must
    // leave room, otherwise the returning word would have nowhere to go.
    assign w_credit_ok = ({1'b0, r_count} + SUM_W'(r_vld_p1)) < SUM_W'(FIFO_DEPTH);
    assign w_issue     = (r_state == S_BURST) && w_credit_ok;
    assign w_empty     = (r_count == '0);
    assign w_push      = r_vld_p1;
    assign w_pop       = !w_empty && rsp_ready;
    assign w_head      = r_mem[r_rptr];

    // ---- Stage 0: command acceptance and address generation ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur_addr  <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state     <= S_BURST;
                        r_cur_addr  <= cmd_addr;
                        r_remaining <= cmd_len;
                    end
                end
                S_BURST: begin
                    if (w_issue) begin
                        // Address wraps naturally at 2^addrLen.
                        r_cur_addr  <= r_cur_addr + addrLen'(1);
                        r_remaining <= r_remaining - lenLen'(1);
                        if (r_remaining == '0) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---- Stage 1: read in flight, ROM registers data for the issued address ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_issue;
        end
    end

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_last_p1 <= (r_remaining == '0);
        end
    end

    // ---- Stage 2: capture returned word into the response FIFO ----
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_last_p1, rom_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Outputs. The head is masked while empty so a flushed FIFO shows zero
    // rather than whatever stale word the storage still holds.
    assign cmd_ready = (r_state == S_IDLE);
    assign rom_addr  = r_cur_addr;
    assign rsp_valid = !w_empty;
    assign rsp_data  = w_empty ? '0 : w_head[dataLen-1:0];
    assign rsp_last  = !w_empty && w_head[dataLen];
    assign busy      = (r_state == S_BURST) || r_vld_p1 || !w_empty;

endmodule
